// File: rtl/ddr2_blk_wr_sched.sv
// Block-granular write scheduler: arbitrates two 64-bit requesters, issues one DDR2 block-write
// command per grant and streams one block into the converter. Define DDR2_BLK_WR_SCHED_STRICT_PRI_EN
// for fixed priority (requester 0 first); the default build arbitrates round-robin.

module ddr2_blk_wr_sched_ptr #(
   parameter int REGION_BLKS = 1024,
   parameter int PTR_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   output logic [PTR_W-1:0] ptr
);
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (adv)
         ptr <= (ptr == PTR_W'(REGION_BLKS - 1)) ? '0 : ptr + PTR_W'(1);
   end
endmodule

module ddr2_blk_wr_sched #(
   parameter int BLK_WORDS64 = 36,
   parameter int ADDR_W      = 22,
   parameter int BASE0       = 0,
   parameter int BASE1       = 'h200000,
   parameter int BLK_STRIDE  = 32,
   parameter int REGION_BLKS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_blk_avail,
   input  logic [63:0]       req0_data,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req1_blk_avail,
   input  logic [63:0]       req1_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   output logic [63:0]       cvt_wr_data,
   output logic              cvt_wr_en,
   input  logic              cvt_full,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              cmd_src,
   output logic              blk_done,
   output logic              blk_done_src
);
   localparam int PTR_W  = (REGION_BLKS > 1) ? $clog2(REGION_BLKS) : 1;
   localparam int PROD_W = ADDR_W + PTR_W;

   typedef enum logic [1:0] {IDLE, CMD, XFER} state_t;

   state_t                  state, state_nxt;
   logic [1:0][63:0]        req_data;
   logic [1:0]              req_valid;
   logic [1:0]              adv;
   logic [1:0][PTR_W-1:0]   ptr;
   logic [7:0]              wcnt;
   logic                    any_avail, win, xfer_rdy, last_xfer;
   logic [PROD_W-1:0]       base_sel, prod;
   logic [ADDR_W-1:0]       addr_nxt;

   assign req_data  = {req1_data, req0_data};
   assign req_valid = {req1_valid, req0_valid};
   assign any_avail = req0_blk_avail | req1_blk_avail;

`ifdef DDR2_BLK_WR_SCHED_STRICT_PRI_EN
   assign win = !req0_blk_avail;
`else
   logic rr_fav;  // requester that wins a tie; flips to the other side after each block

   assign win = (req0_blk_avail && req1_blk_avail) ? rr_fav : !req0_blk_avail;

   always_ff @(posedge clk) begin
      if (rst)
         rr_fav <= 1'b0;
      else if (last_xfer)
         rr_fav <= ~cmd_src;
   end
`endif

   // Block pointer per requester; advances on the last word of its own block
   for (genvar g = 0; g < 2; g++) begin : g_ptr
      assign adv[g] = last_xfer && (cmd_src == 1'(g));
      ddr2_blk_wr_sched_ptr #(.REGION_BLKS(REGION_BLKS), .PTR_W(PTR_W)) u_ptr (
         .clk (clk),
         .rst (rst),
         .adv (adv[g]),
         .ptr (ptr[g])
      );
   end

   always_comb begin
      base_sel = win ? PROD_W'(BASE1) : PROD_W'(BASE0);
      prod     = PROD_W'(ptr[win]) * PROD_W'(BLK_STRIDE);
      addr_nxt = ADDR_W'(base_sel + prod);
   end

   // Data path is a pure passthrough; the grant is fixed for the whole block
   assign xfer_rdy    = (state == XFER) && !cvt_full;
   assign req0_ready  = xfer_rdy && !cmd_src;
   assign req1_ready  = xfer_rdy && cmd_src;
   assign cvt_wr_en   = xfer_rdy && req_valid[cmd_src];
   assign cvt_wr_data = cvt_wr_en ? req_data[cmd_src] : '0;
   assign last_xfer   = cvt_wr_en && (wcnt == 8'(BLK_WORDS64 - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_valid = 1'b0;
      case (state)
         IDLE: if (any_avail) state_nxt = CMD;
         CMD: begin
            cmd_valid = 1'b1;
            if (cmd_ready) state_nxt = XFER;
         end
         XFER: if (last_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_src      <= 1'b0;
         cmd_addr     <= '0;
         wcnt         <= '0;
         blk_done     <= 1'b0;
         blk_done_src <= 1'b0;
      end else begin
         blk_done <= last_xfer;
         if (last_xfer)
            blk_done_src <= cmd_src;
         if (state == IDLE && any_avail) begin
            cmd_src  <= win;
            cmd_addr <= addr_nxt;
         end
         if (state == CMD && cmd_ready)
            wcnt <= '0;
         else if (cvt_wr_en)
            wcnt <= wcnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_ddr2_blk_wr_sched.sv
// Scoreboard bench for ddr2_blk_wr_sched: expected commands, words and block-done events are queued
// when stimulus is set up and checked by a negedge monitor as the DUT produces them.
module tb_ddr2_blk_wr_sched;
   localparam int BW = 36;

   typedef struct packed {
      logic        src;
      logic [21:0] addr;
   } cmd_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req0_blk_avail = 0, req0_valid = 0, req1_blk_avail = 0, req1_valid = 0;
   logic [63:0] req0_data = 64'd0, req1_data = {31'd0, 1'b1, 32'd0};
   logic        req0_ready, req1_ready;
   logic [63:0] cvt_wr_data;
   logic        cvt_wr_en, cvt_full = 0;
   logic        cmd_valid, cmd_ready = 0, cmd_src, blk_done, blk_done_src;
   logic [21:0] cmd_addr;

   int   n_chk = 0, n_fail = 0;
   cmd_t        exp_cmd[$];
   logic [63:0] exp_data[$];
   logic        exp_done[$];
   int   exp_base[2] = '{0, 0};
   int   cnt[2] = '{0, 0};
   int   cmds_seen = 0, words_seen = 0, cyc = 0, last_wr_cyc = -10;
   bit   b2b = 0, armed = 0;
   logic        prev_cv = 0, prev_hs = 0;
   logic [21:0] prev_addr = '0;

   ddr2_blk_wr_sched #(.REGION_BLKS(4)) dut (
      .clk(clk), .rst(rst),
      .req0_blk_avail(req0_blk_avail), .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_blk_avail(req1_blk_avail), .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .cvt_wr_data(cvt_wr_data), .cvt_wr_en(cvt_wr_en), .cvt_full(cvt_full),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_src(cmd_src),
      .blk_done(blk_done), .blk_done_src(blk_done_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, advance the sources just after the edge
   task automatic tick();
      logic a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin cnt[0]++; req0_data = {32'd0, 32'(cnt[0])}; end
      if (a1) begin cnt[1]++; req1_data = {31'd0, 1'b1, 32'(cnt[1])}; end
   endtask

   task automatic exp_blk(input logic src, input logic [21:0] addr);
      cmd_t c;
      c.src  = src;
      c.addr = addr;
      exp_cmd.push_back(c);
      for (int k = 0; k < BW; k++) exp_data.push_back({31'd0, src, 32'(exp_base[src] + k)});
      exp_base[src] += BW;
      exp_done.push_back(src);
   endtask

   // Drop each avail once the given number of commands has handshaken, then drain the scoreboard
   task automatic run_blks(input int d0, input int d1, input int budget);
      int s = cmds_seen;
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (cmds_seen >= s + d0) req0_blk_avail = 0;
         if (cmds_seen >= s + d1) req1_blk_avail = 0;
         if (!req0_blk_avail && !req1_blk_avail && exp_cmd.size() == 0 &&
             exp_data.size() == 0 && exp_done.size() == 0) ok = 1;
      end
      chk("run_drain", 64'(ok), 64'd1);
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int i = 0; i < budget && words_seen < n; i++) tick();
      chk("word_count", 64'(words_seen), 64'(n));
   endtask

   task automatic chk_rst_outputs(input string tag);
      chk({tag, "_rdy0"},   64'(req0_ready),   64'd0);
      chk({tag, "_rdy1"},   64'(req1_ready),   64'd0);
      chk({tag, "_wren"},   64'(cvt_wr_en),    64'd0);
      chk({tag, "_wdata"},  cvt_wr_data,       64'd0);
      chk({tag, "_cmdv"},   64'(cmd_valid),    64'd0);
      chk({tag, "_addr"},   64'(cmd_addr),     64'd0);
      chk({tag, "_src"},    64'(cmd_src),      64'd0);
      chk({tag, "_done"},   64'(blk_done),     64'd0);
      chk({tag, "_dsrc"},   64'(blk_done_src), 64'd0);
   endtask

   always @(negedge clk) begin
      cmd_t        c;
      logic [63:0] d;
      logic        s;
      cyc++;
      if (cvt_full) chk("wr_while_full", 64'(cvt_wr_en), 64'd0);
      if (prev_cv && !prev_hs && cmd_valid && !rst) chk("addr_stable", 64'(cmd_addr), 64'(prev_addr));
      if (cmd_valid && !prev_cv && armed) begin
         chk("next_cmd_lat", 64'(cyc), 64'(last_wr_cyc + 2));
         armed = 0;
      end
      if (cmd_valid && cmd_ready) begin
         if (exp_cmd.size() == 0) chk("cmd_unexp", 64'(cmd_valid), 64'd0);
         else begin
            c = exp_cmd.pop_front();
            chk("cmd_src", 64'(cmd_src), 64'(c.src));
            chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
         end
         cmds_seen++;
      end
      if (cvt_wr_en) begin
         if (exp_data.size() == 0) chk("wr_unexp", 64'(cvt_wr_en), 64'd0);
         else begin
            d = exp_data.pop_front();
            chk("wr_data", cvt_wr_data, d);
         end
         words_seen++;
         last_wr_cyc = cyc;
      end
      if (blk_done) begin
         if (exp_done.size() == 0) chk("done_unexp", 64'(blk_done), 64'd0);
         else begin
            s = exp_done.pop_front();
            chk("done_src", 64'(blk_done_src), 64'(s));
         end
         chk("done_lat", 64'(cyc), 64'(last_wr_cyc + 1));
         chk("blk_words", 64'(words_seen), 64'(BW));
         words_seen = 0;
         if (b2b) armed = 1;
      end
      prev_cv   = cmd_valid;
      prev_hs   = cmd_valid && cmd_ready;
      prev_addr = cmd_addr;
   end

   initial begin
      // Reset state
      tick(); tick();
      chk_rst_outputs("reset");
      rst = 0;
      tick();

      // Single block from requester 0, then command latency
      req0_valid = 1; cmd_ready = 1; req0_blk_avail = 1;
      exp_blk(1'b0, 22'd0);
      tick();
      chk("cmd_lat", 64'(cmd_valid), 64'd1);
      run_blks(1, 1, 200);

      // Second requester-0 block at address 32, abandoned by reset after 10 words
      req0_blk_avail = 1;
      exp_blk(1'b0, 22'd32);
      for (int i = 0; i < 200 && words_seen < 10; i++) begin
         tick();
         if (words_seen > 0) req0_blk_avail = 0;
      end
      chk("pre_rst_words", 64'(words_seen), 64'd10);
      req0_valid = 0; req0_blk_avail = 0; rst = 1;
      tick();
      chk_rst_outputs("midrst");
      rst = 0;
      exp_data.delete();
      exp_done.delete();
      exp_base[0] -= BW - 10;
      words_seen = 0;

      // Next block after reset: src 0 addr 0, with command and converter back-pressure
      req0_valid = 1; cmd_ready = 0; req0_blk_avail = 1;
      exp_blk(1'b0, 22'd0);
      tick();
      chk("cmd_wait_valid", 64'(cmd_valid), 64'd1);
      tick(); tick();
      chk("cmd_wait_valid2", 64'(cmd_valid), 64'd1);
      cmd_ready = 1;
      tick();
      req0_blk_avail = 0;
      wait_words(12, 100);
      chk("rdy1_nongrant", 64'(req1_ready), 64'd0);
      cvt_full = 1;
      repeat (5) begin
         #1;
         chk("rdy0_full", 64'(req0_ready), 64'd0);
         chk("wren_full", 64'(cvt_wr_en), 64'd0);
         tick();
      end
      cvt_full = 0;
      wait_words(35, 100);
      cvt_full = 1;
      tick(); tick();
      chk("last_word_held", 64'(words_seen), 64'd35);
      cvt_full = 0;
      run_blks(0, 0, 100);

      // Pointer wrap with REGION_BLKS=4, back to back
      rst = 1; tick(); rst = 0;
      b2b = 1; armed = 0;
      req0_blk_avail = 1;
      exp_blk(1'b0, 22'd0); exp_blk(1'b0, 22'd32); exp_blk(1'b0, 22'd64);
      exp_blk(1'b0, 22'd96); exp_blk(1'b0, 22'd0);
      run_blks(5, 5, 600);
      armed = 0;

      // Both requesters available
      rst = 1; tick(); rst = 0;
      armed = 0;
      req1_valid = 1; req0_blk_avail = 1; req1_blk_avail = 1;
`ifdef DDR2_BLK_WR_SCHED_STRICT_PRI_EN
      exp_blk(1'b0, 22'd0); exp_blk(1'b0, 22'd32); exp_blk(1'b0, 22'd64);
      exp_blk(1'b1, 22'h200000);
      run_blks(3, 4, 600);
`else
      exp_blk(1'b0, 22'd0); exp_blk(1'b1, 22'h200000);
      exp_blk(1'b0, 22'd32); exp_blk(1'b1, 22'h200020);
      run_blks(4, 4, 600);
`endif
      b2b = 0; armed = 0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
